// File: rtl/fifo_queue.sv
// fifo_queue: single-clock first-in/first-out buffer between a producer and a consumer.
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   push      write request, data_in sampled on the rising edge
//   pop       read request, oldest entry registered onto data_out
//   data_in   write data
//   data_out  registered read data, holds when no pop is accepted
//   full      count == fifo_depth (decode of count)
//   empty     count == 0 (decode of count)
//   count     number of occupied entries
// Optional feature macro: FIFO_ERR_EN adds sticky overflow/underflow outputs.
module fifo_queue #(
  parameter int unsigned data_width = 8,
  parameter int unsigned fifo_depth = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [data_width-1:0]         data_in,
  output logic [data_width-1:0]         data_out,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(fifo_depth):0]   count
`ifdef FIFO_ERR_EN
  ,
  output logic                          overflow,
  output logic                          underflow
`endif
);

  localparam int unsigned ptr_w = $clog2(fifo_depth);
  localparam int unsigned cnt_w = ptr_w + 1;

  logic [data_width-1:0] mem [fifo_depth];
  logic [ptr_w-1:0]      wr_ptr;
  logic [ptr_w-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Status decodes of the occupancy register.
  assign full  = (count == cnt_w'(fifo_depth));
  assign empty = (count == cnt_w'(0));

  // Acceptance: a pop frees a slot, so push is still taken when full and popping.
  // When empty, pop is refused and no fall-through to data_out occurs.
  always_comb begin
    do_pop  = 1'b0;
    do_push = 1'b0;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy and read data; pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + ptr_w'(1);
      end
      if (do_pop) begin
        rd_ptr   <= rd_ptr + ptr_w'(1);
        data_out <= mem[rd_ptr];
      end
      if (do_push && !do_pop) begin
        count <= count + cnt_w'(1);
      end else if (do_pop && !do_push) begin
        count <= count - cnt_w'(1);
      end
    end
  end

`ifdef FIFO_ERR_EN
  // Sticky error flags for dropped requests; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full && !do_pop) begin
        overflow <= 1'b1;
      end
      if (pop && empty && !do_push) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_queue.sv
// Bench for fifo_queue: queue-based reference model checked every cycle, plus directed literals.
module tb_fifo_queue;

  localparam int unsigned dw    = 8;
  localparam int unsigned depth = 8;

  logic          clk;
  logic          rst;
  logic          push;
  logic          pop;
  logic [dw-1:0] data_in;
  logic [dw-1:0] data_out;
  logic          full;
  logic          empty;
  logic [3:0]    count;
`ifdef FIFO_ERR_EN
  logic          overflow;
  logic          underflow;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fifo_queue #(.data_width(dw), .fifo_depth(depth)) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty),
    .count    (count)
`ifdef FIFO_ERR_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: a plain queue with the acceptance rules applied directly.
  logic [dw-1:0] q[$];
  logic [dw-1:0] m_dout = '0;
  logic          m_ovf  = 1'b0;
  logic          m_unf  = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      int  n;
      bit  take_pop;
      bit  take_push;
      n         = q.size();
      take_pop  = pop && (n > 0);
      take_push = push && ((n < depth) || take_pop);
      if (push && (n == depth) && !take_pop) m_ovf = 1'b1;
      if (pop && (n == 0) && !take_push)     m_unf = 1'b1;
      if (take_pop)  m_dout = q.pop_front();
      if (take_push) q.push_back(data_in);
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("model_count", 32'(count), 32'(q.size()));
      chk("model_empty", 32'(empty), 32'(q.size() == 0));
      chk("model_full",  32'(full),  32'(q.size() == depth));
      chk("model_dout",  32'(data_out), 32'(m_dout));
`ifdef FIFO_ERR_EN
      chk("model_ovf", 32'(overflow),  32'(m_ovf));
      chk("model_unf", 32'(underflow), 32'(m_unf));
`endif
    end
  end

  task automatic step(input logic p, input logic po, input logic [dw-1:0] d);
    push    = p;
    pop     = po;
    data_in = d;
    @(negedge clk);
  endtask

  initial begin
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;
    rst     = 1'b1;
    #1 rst  = 1'b0;

    // 1: reset state, checked at a negedge and again mid-cycle
    @(negedge clk);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dout",  32'(data_out), 32'h00);
    #2;
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_empty", 32'(empty), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 8'h00);

    // 2: basic ordering and pop while empty
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b0, 8'h33);
    step(1'b0, 1'b1, 8'h00);
    chk("t2_pop0", 32'(data_out), 32'h11);
    step(1'b0, 1'b1, 8'h00);
    chk("t2_pop1", 32'(data_out), 32'h22);
    step(1'b0, 1'b1, 8'h00);
    chk("t2_pop2", 32'(data_out), 32'h33);
    chk("t2_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b1, 8'h00);
    chk("t2_pop_empty", 32'(data_out), 32'h33);
`ifdef FIFO_ERR_EN
    chk("t2_underflow", 32'(underflow), 32'd1);
`endif

    // 3: fill to full, overfill, drain
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'hA0 + i));
    chk("t3_full",  32'(full),  32'd1);
    chk("t3_count", 32'(count), 32'd8);
    step(1'b1, 1'b0, 8'hFF);
    chk("t3_count_ovf", 32'(count), 32'd8);
`ifdef FIFO_ERR_EN
    chk("t3_overflow", 32'(overflow), 32'd1);
`endif
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("t3_drain", 32'(data_out), 32'(8'hA0 + i));
    end
    chk("t3_empty", 32'(empty), 32'd1);

    // 4: streaming push+pop across pointer wrap with one word preloaded
    step(1'b1, 1'b0, 8'hEE);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'(i));
      chk("t4_stream", 32'(data_out), (i == 0) ? 32'hEE : 32'(i - 1));
      chk("t4_count",  32'(count), 32'd1);
    end
    step(1'b0, 1'b1, 8'h00);
    chk("t4_last", 32'(data_out), 32'h13);

    // 5: simultaneous push+pop at empty and at full
    step(1'b1, 1'b1, 8'h55);
    chk("t5_empty_cnt",  32'(count), 32'd1);
    chk("t5_empty_dout", 32'(data_out), 32'h13);
    for (int i = 1; i < 8; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    chk("t5_full", 32'(full), 32'd1);
    step(1'b1, 1'b1, 8'h66);
    chk("t5_full_cnt",  32'(count), 32'd8);
    chk("t5_full_dout", 32'(data_out), 32'h55);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("t5_drain", 32'(data_out), 32'(8'hC0 + i));
    end
    step(1'b0, 1'b1, 8'h00);
    chk("t5_last", 32'(data_out), 32'h66);

    // 6: asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h90 + i));
    push = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_dout",  32'(data_out), 32'h00);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b1, 8'h00);
    chk("t6_dout_77", 32'(data_out), 32'h77);
    chk("t6_empty_end", 32'(empty), 32'd1);
    step(1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
